// File: rtl/cache_mem_arb.sv
// ============================================================================
// Module   : cache_mem_arb
// Purpose  : Round-robin two-to-one Avalon-MM burst arbiter for I/D caches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mem_arb #(
    parameter int BURST_COUNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rest,

    input  logic [31:0]                  s0_address,
    input  logic [3:0]                   s0_byteEnable,
    input  logic                         s0_read,
    input  logic                         s0_write,
    input  logic [31:0]                  s0_writeData,
    input  logic                         s0_beginBurstTransfer,
    input  logic [BURST_COUNT_WIDTH-1:0] s0_burstCount,
    output logic                         s0_waitRequest,
    output logic [31:0]                  s0_readData,
    output logic                         s0_readDataValid,

    input  logic [31:0]                  s1_address,
    input  logic [3:0]                   s1_byteEnable,
    input  logic                         s1_read,
    input  logic                         s1_write,
    input  logic [31:0]                  s1_writeData,
    input  logic                         s1_beginBurstTransfer,
    input  logic [BURST_COUNT_WIDTH-1:0] s1_burstCount,
    output logic                         s1_waitRequest,
    output logic [31:0]                  s1_readData,
    output logic                         s1_readDataValid,

    output logic [31:0]                  m0_address,
    output logic [3:0]                   m0_byteEnable,
    output logic                         m0_read,
    output logic                         m0_write,
    output logic [31:0]                  m0_writeData,
    output logic                         m0_beginBurstTransfer,
    output logic [BURST_COUNT_WIDTH-1:0] m0_burstCount,
    input  logic                         m0_waitRequest,
    input  logic [31:0]                  m0_readData,
    input  logic                         m0_readDataValid,

    output logic                         bus_idle,
    output logic                         grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        WR      = 2'd3
    } state_t;

    localparam logic [BURST_COUNT_WIDTH-1:0] C_ONE = BURST_COUNT_WIDTH'(1);

    state_t                         state_q, state_d;
    logic                           grant_q, grant_d;
    logic                           ptr_q, ptr_d;
    logic [BURST_COUNT_WIDTH-1:0]   count_q, count_d;

    logic                           w_req0, w_req1, w_arb, w_arb_write;
    logic                           w_sel_read, w_sel_write, w_sel_bbt;
    logic [BURST_COUNT_WIDTH-1:0]   w_sel_bc, w_bc_eff;
    logic                           w_wait_g, w_rdv_g;

    assign w_req0      = s0_read | s0_write;
    assign w_req1      = s1_read | s1_write;
    // ptr_q holds the last finishing port, so on contention the other one wins.
    assign w_arb       = (w_req0 & w_req1) ? ~ptr_q : w_req1;
    assign w_arb_write = w_arb ? s1_write : s0_write;

    assign w_sel_read  = grant_q ? s1_read               : s0_read;
    assign w_sel_write = grant_q ? s1_write              : s0_write;
    assign w_sel_bbt   = grant_q ? s1_beginBurstTransfer : s0_beginBurstTransfer;
    assign w_sel_bc    = grant_q ? s1_burstCount         : s0_burstCount;
    assign w_bc_eff    = (w_sel_bc == '0) ? C_ONE : w_sel_bc;

    assign m0_address    = grant_q ? s1_address    : s0_address;
    assign m0_byteEnable = grant_q ? s1_byteEnable : s0_byteEnable;
    assign m0_writeData  = grant_q ? s1_writeData  : s0_writeData;
    assign m0_burstCount = w_sel_bc;

    assign s0_readData = m0_readData;
    assign s1_readData = m0_readData;
    assign bus_idle    = (state_q == IDLE);
    assign grant       = grant_q;

    always_comb begin
        state_d               = state_q;
        grant_d               = grant_q;
        ptr_d                 = ptr_q;
        count_d               = count_q;
        m0_read               = 1'b0;
        m0_write              = 1'b0;
        m0_beginBurstTransfer = 1'b0;
        w_wait_g              = 1'b1;
        w_rdv_g               = 1'b0;

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (w_req0 | w_req1) begin
                    grant_d = w_arb;
                    state_d = w_arb_write ? WR : RD_CMD;
                end
            end
            RD_CMD: begin
                m0_read               = w_sel_read;
                m0_beginBurstTransfer = w_sel_bbt;
                w_wait_g              = m0_waitRequest;
                if (!m0_waitRequest) begin
                    count_d = w_bc_eff;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                w_rdv_g = m0_readDataValid;
                if (m0_readDataValid) begin
                    if (count_q == C_ONE) begin
                        count_d = '0;
                        ptr_d   = grant_q;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q - C_ONE;
                    end
                end
            end
            WR: begin
                // count_q is zero until the first beat is accepted, marking the first beat.
                m0_write              = w_sel_write;
                m0_beginBurstTransfer = w_sel_bbt & (count_q == '0);
                w_wait_g              = m0_waitRequest;
                if (w_sel_write && !m0_waitRequest) begin
                    if ((count_q == '0 && w_bc_eff == C_ONE) || count_q == C_ONE) begin
                        count_d = '0;
                        ptr_d   = grant_q;
                        state_d = IDLE;
                    end else if (count_q == '0) begin
                        count_d = w_bc_eff - C_ONE;
                    end else begin
                        count_d = count_q - C_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        s0_waitRequest   = grant_q ? 1'b1 : w_wait_g;
        s1_waitRequest   = grant_q ? w_wait_g : 1'b1;
        s0_readDataValid = ~grant_q & w_rdv_g;
        s1_readDataValid =  grant_q & w_rdv_g;
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            ptr_q   <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arb.sv
// ============================================================================
// Module   : tb_cache_mem_arb
// Purpose  : Directed vector and sequence bench for cache_mem_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_mem_arb;

    localparam int BCW = 8;

    logic clk = 1'b0;
    logic rest = 1'b0;

    logic [31:0]    s0_address, s1_address, s0_writeData, s1_writeData;
    logic [3:0]     s0_byteEnable, s1_byteEnable;
    logic           s0_read, s0_write, s0_beginBurstTransfer;
    logic           s1_read, s1_write, s1_beginBurstTransfer;
    logic [BCW-1:0] s0_burstCount, s1_burstCount;
    logic           s0_waitRequest, s1_waitRequest;
    logic [31:0]    s0_readData, s1_readData;
    logic           s0_readDataValid, s1_readDataValid;
    logic [31:0]    m0_address, m0_writeData, m0_readData;
    logic [3:0]     m0_byteEnable;
    logic           m0_read, m0_write, m0_beginBurstTransfer;
    logic [BCW-1:0] m0_burstCount;
    logic           m0_waitRequest, m0_readDataValid;
    logic           bus_idle, grant;

    int n_checks = 0;
    int n_fail   = 0;

    cache_mem_arb #(.BURST_COUNT_WIDTH(BCW)) dut (
        .clk(clk), .rest(rest),
        .s0_address(s0_address), .s0_byteEnable(s0_byteEnable), .s0_read(s0_read),
        .s0_write(s0_write), .s0_writeData(s0_writeData),
        .s0_beginBurstTransfer(s0_beginBurstTransfer), .s0_burstCount(s0_burstCount),
        .s0_waitRequest(s0_waitRequest), .s0_readData(s0_readData),
        .s0_readDataValid(s0_readDataValid),
        .s1_address(s1_address), .s1_byteEnable(s1_byteEnable), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writeData(s1_writeData),
        .s1_beginBurstTransfer(s1_beginBurstTransfer), .s1_burstCount(s1_burstCount),
        .s1_waitRequest(s1_waitRequest), .s1_readData(s1_readData),
        .s1_readDataValid(s1_readDataValid),
        .m0_address(m0_address), .m0_byteEnable(m0_byteEnable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writeData(m0_writeData),
        .m0_beginBurstTransfer(m0_beginBurstTransfer), .m0_burstCount(m0_burstCount),
        .m0_waitRequest(m0_waitRequest), .m0_readData(m0_readData),
        .m0_readDataValid(m0_readDataValid),
        .bus_idle(bus_idle), .grant(grant)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic r0, w0, r1, w1;
        logic g, rd, wr, idle;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        s0_address = '0; s0_byteEnable = 4'hF; s0_read = 0; s0_write = 0;
        s0_writeData = '0; s0_beginBurstTransfer = 0; s0_burstCount = 8'd1;
        s1_address = '0; s1_byteEnable = 4'hF; s1_read = 0; s1_write = 0;
        s1_writeData = '0; s1_beginBurstTransfer = 0; s1_burstCount = 8'd1;
        m0_waitRequest = 0; m0_readData = '0; m0_readDataValid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rest = 1'b0;
        repeat (2) @(posedge clk);
        #1 rest = 1'b1;
    endtask

    // Drives n read beats back to back and tallies what each port sees.
    task automatic read_beats(input int n, input logic [31:0] base, input logic g,
                              output int c0, output int c1, output int errs);
        c0 = 0; c1 = 0; errs = 0;
        for (int i = 0; i < n; i++) begin
            m0_readDataValid = 1'b1;
            m0_readData      = base + 32'(i);
            settle();
            c0 += int'(s0_readDataValid);
            c1 += int'(s1_readDataValid);
            if ((g ? s1_readData : s0_readData) !== base + 32'(i)) errs++;
            if (s0_waitRequest !== 1'b1 || s1_waitRequest !== 1'b1 || m0_read !== 1'b0) errs++;
            tick();
        end
        m0_readDataValid = 1'b0;
    endtask

    initial begin
        int c0, c1, e, acc, cnt;
        logic wp [6];

        vecs[0] = '{r0:1, w0:0, r1:0, w1:0, g:0, rd:1, wr:0, idle:0};
        vecs[1] = '{r0:0, w0:1, r1:0, w1:0, g:0, rd:0, wr:1, idle:0};
        vecs[2] = '{r0:0, w0:0, r1:1, w1:0, g:1, rd:1, wr:0, idle:0};
        vecs[3] = '{r0:0, w0:0, r1:0, w1:1, g:1, rd:0, wr:1, idle:0};
        vecs[4] = '{r0:1, w0:0, r1:1, w1:0, g:0, rd:1, wr:0, idle:0};
        vecs[5] = '{r0:0, w0:1, r1:1, w1:0, g:0, rd:0, wr:1, idle:0};
        vecs[6] = '{r0:1, w0:1, r1:0, w1:0, g:0, rd:0, wr:1, idle:0};
        vecs[7] = '{r0:0, w0:0, r1:0, w1:0, g:0, rd:0, wr:0, idle:1};

        clear_inputs();
        m0_readDataValid = 1'b1;
        #3;
        check("reset bus_idle", bus_idle, 1);
        check("reset grant", grant, 0);
        check("reset s0_wait", s0_waitRequest, 1);
        check("reset s1_wait", s1_waitRequest, 1);
        check("reset m0_rd_wr_bbt", {m0_read, m0_write, m0_beginBurstTransfer}, 0);
        check("reset rdv", {s0_readDataValid, s1_readDataValid}, 0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            s0_read = vecs[i].r0; s0_write = vecs[i].w0;
            s1_read = vecs[i].r1; s1_write = vecs[i].w1;
            settle();
            check($sformatf("vec%0d idle waits", i), {s0_waitRequest, s1_waitRequest, m0_read, m0_write}, 4'b1100);
            tick();
            settle();
            check($sformatf("vec%0d grant", i), grant, vecs[i].g);
            check($sformatf("vec%0d m0_read", i), m0_read, vecs[i].rd);
            check($sformatf("vec%0d m0_write", i), m0_write, vecs[i].wr);
            check($sformatf("vec%0d bus_idle", i), bus_idle, vecs[i].idle);
        end

        // Single read from s0, data three cycles after acceptance.
        do_reset();
        s0_address = 32'h0000_1000; s0_burstCount = 8'd1; s0_beginBurstTransfer = 1; s0_read = 1;
        settle();
        check("t1 m0_read before arb", m0_read, 0);
        tick(); settle();
        check("t1 m0_read", m0_read, 1);
        check("t1 m0_address", m0_address, 32'h0000_1000);
        check("t1 s0_wait", s0_waitRequest, 0);
        tick();
        s0_read = 0; s0_beginBurstTransfer = 0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            m0_readDataValid = (k == 2);
            m0_readData      = (k == 2) ? 32'hDEAD_BEEF : 32'h0;
            settle();
            cnt += int'(s0_readDataValid);
            if (k == 2) check("t1 readData", s0_readData, 32'hDEAD_BEEF);
            tick();
        end
        m0_readDataValid = 0;
        settle();
        check("t1 rdv count", cnt, 1);
        check("t1 bus_idle", bus_idle, 1);

        // Simultaneous 8-beat reads: s0 first, then s1.
        do_reset();
        s0_address = 32'h2000; s0_burstCount = 8'd8; s0_read = 1;
        s1_address = 32'h3000; s1_burstCount = 8'd8; s1_read = 1;
        tick(); settle();
        check("t2 first grant", grant, 0);
        check("t2 m0_address s0", m0_address, 32'h2000);
        check("t2 m0_burstCount", m0_burstCount, 8);
        check("t2 s1_wait held", s1_waitRequest, 1);
        tick();
        s0_read = 0;
        read_beats(8, 32'h100, 1'b0, c0, c1, e);
        check("t2 s0 beats", c0, 8);
        check("t2 s1 beats during s0", c1, 0);
        check("t2 s0 beat errors", e, 0);
        settle();
        check("t2 idle between", bus_idle, 1);
        tick(); settle();
        check("t2 second grant", grant, 1);
        check("t2 m0_address s1", m0_address, 32'h3000);
        check("t2 m0_read s1", m0_read, 1);
        tick();
        s1_read = 0;
        read_beats(8, 32'h200, 1'b1, c0, c1, e);
        check("t2 s1 beats", c1, 8);
        check("t2 s0 beats during s1", c0, 0);
        check("t2 s1 beat errors", e, 0);

        // 4-beat write from s1 with m0_waitRequest 1,0,1,0,0,0.
        wp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        s1_address = 32'h4000; s1_burstCount = 8'd4; s1_beginBurstTransfer = 1;
        s1_write = 1; s1_writeData = 32'hA5A5_0000; m0_waitRequest = 1;
        tick();
        acc = 0; e = 0;
        for (int k = 0; k < 6; k++) begin
            m0_waitRequest = wp[k];
            settle();
            if (s1_waitRequest !== wp[k] || s0_waitRequest !== 1'b1 || grant !== 1'b1) e++;
            if (m0_write && !m0_waitRequest) begin
                check($sformatf("t3 bbt on beat %0d", acc), m0_beginBurstTransfer, (acc == 0));
                acc++;
            end
            tick();
            s1_writeData = s1_writeData + 1;
        end
        s1_write = 0; s1_beginBurstTransfer = 0; m0_waitRequest = 0;
        settle();
        check("t3 accepted beats", acc, 4);
        check("t3 wait mirror errors", e, 0);
        check("t3 bus_idle", bus_idle, 1);

        // Back-to-back contention alternates s0, s1, s0, s1.
        s0_address = 32'h5000; s0_burstCount = 8'd1; s0_read = 1;
        s1_address = 32'h6000; s1_burstCount = 8'd1; s1_read = 1;
        for (int t = 0; t < 4; t++) begin
            tick(); settle();
            check($sformatf("t4 grant %0d", t), grant, t % 2);
            check($sformatf("t4 other wait %0d", t), (t % 2) ? s0_waitRequest : s1_waitRequest, 1);
            tick();
            m0_readDataValid = 1; m0_readData = 32'(t);
            settle();
            check($sformatf("t4 rdv %0d", t), (t % 2) ? s1_readDataValid : s0_readDataValid, 1);
            tick();
            m0_readDataValid = 0;
        end
        s0_read = 0; s1_read = 0;

        // Reset after the 2nd of 8 beats; stale beats must be dropped.
        do_reset();
        s0_address = 32'h7000; s0_burstCount = 8'd8; s0_read = 1;
        tick(); tick();
        s0_read = 0;
        read_beats(2, 32'h300, 1'b0, c0, c1, e);
        check("t5 pre-reset beats", c0, 2);
        m0_readDataValid = 1;
        #2 rest = 0;
        #1;
        check("t5 reset bus_idle", bus_idle, 1);
        check("t5 reset rdv", {s0_readDataValid, s1_readDataValid}, 0);
        check("t5 reset s0_wait", s0_waitRequest, 1);
        tick();
        rest = 1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            m0_readDataValid = 1; m0_readData = 32'hBAD0_0000 + 32'(k);
            settle();
            cnt += int'(s0_readDataValid) + int'(s1_readDataValid);
            tick();
        end
        check("t5 stale beats forwarded", cnt, 0);
        s1_address = 32'h8000; s1_burstCount = 8'd1; s1_read = 1; m0_waitRequest = 1;
        tick(); settle();
        check("t5 s1 grant", grant, 1);
        check("t5 s1 m0_read", m0_read, 1);
        check("t5 stale in RD_CMD", s1_readDataValid, 0);
        m0_waitRequest = 0;
        tick();
        s1_read = 0;
        m0_readData = 32'hCAFE_0001;
        settle();
        check("t5 s1 rdv", s1_readDataValid, 1);
        check("t5 s1 data", s1_readData, 32'hCAFE_0001);
        tick();
        m0_readDataValid = 0;
        settle();
        check("t5 bus_idle", bus_idle, 1);

        // burstCount=0 read is a single beat.
        s0_address = 32'h9000; s0_burstCount = 8'd0; s0_read = 1;
        tick(); settle();
        check("t6 m0_burstCount", m0_burstCount, 0);
        tick();
        s0_read = 0;
        m0_readDataValid = 1; m0_readData = 32'h1234_5678;
        settle();
        check("t6 s0 rdv", s0_readDataValid, 1);
        tick();
        m0_readDataValid = 0;
        settle();
        check("t6 bus_idle", bus_idle, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
